// File: rtl/laser_cover_eval.sv
// Coverage evaluator downstream of laser placement: snoops a 40-point frame, then
// recounts how many points fall inside the union of the two chosen circles.
module laser_cover_eval #(
    parameter int NPTS      = 40,
    parameter int RADIUS_SQ = 16,
    parameter int CW        = 6
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IN_VALID,
    input  logic [3:0]    X,
    input  logic [3:0]    Y,
    input  logic          DONE,
    input  logic [3:0]    C1X,
    input  logic [3:0]    C1Y,
    input  logic [3:0]    C2X,
    input  logic [3:0]    C2Y,
    input  logic          OUT_READY,
    output logic [CW-1:0] COUNT,
    output logic          COUNT_VALID,
    output logic          BUSY
);
    // state     | meaning
    // COLLECT   | storing incoming points until the frame is full
    // WAIT_DONE | frame stored, waiting for placement result
    // EVAL      | one stored point checked per cycle
    // HOLD      | COUNT presented, waiting for OUT_READY
    typedef enum logic [1:0] {
        S_COLLECT   = 2'd0,
        S_WAIT_DONE = 2'd1,
        S_EVAL      = 2'd2,
        S_HOLD      = 2'd3
    } state_t;

    localparam int              PW   = $clog2(NPTS);
    localparam logic [PW-1:0]   LAST = PW'(NPTS - 1);

    state_t          state, state_nx;
    logic [3:0]      pt_x [NPTS];
    logic [3:0]      pt_y [NPTS];
    logic [PW-1:0]   wr_ptr, idx;
    logic [3:0]      c1x_q, c1y_q, c2x_q, c2y_q;
    logic [CW-1:0]   acc, count_q;
    logic            covered;

    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [8:0] dist_sq(input logic [3:0] px, input logic [3:0] py,
                                           input logic [3:0] cx, input logic [3:0] cy);
        logic [8:0] dx, dy;
        dx = {5'd0, abs_diff(px, cx)};
        dy = {5'd0, abs_diff(py, cy)};
        return dx * dx + dy * dy;
    endfunction

    // A point inside both circles still contributes a single count.
    assign covered = (dist_sq(pt_x[idx], pt_y[idx], c1x_q, c1y_q) <= 9'(RADIUS_SQ)) ||
                     (dist_sq(pt_x[idx], pt_y[idx], c2x_q, c2y_q) <= 9'(RADIUS_SQ));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_COLLECT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_COLLECT:   if (IN_VALID && wr_ptr == LAST) state_nx = S_WAIT_DONE;
            S_WAIT_DONE: if (DONE)                       state_nx = S_EVAL;
            S_EVAL:      if (idx == LAST)                state_nx = S_HOLD;
            S_HOLD:      if (OUT_READY)                  state_nx = S_COLLECT;
            default:                                     state_nx = S_COLLECT;
        endcase
    end

    always_comb begin
        BUSY        = (state == S_EVAL);
        COUNT_VALID = (state == S_HOLD);
        COUNT       = count_q;
    end

    // Point storage survives reset; only the write pointer is cleared.
    always_ff @(posedge CLK) begin
        if (state == S_COLLECT && IN_VALID) begin
            pt_x[wr_ptr] <= X;
            pt_y[wr_ptr] <= Y;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr  <= '0;
            idx     <= '0;
            acc     <= '0;
            count_q <= '0;
            c1x_q   <= '0;
            c1y_q   <= '0;
            c2x_q   <= '0;
            c2y_q   <= '0;
        end else begin
            case (state)
                S_COLLECT: begin
                    if (IN_VALID) wr_ptr <= wr_ptr + PW'(1);
                end
                S_WAIT_DONE: begin
                    if (DONE) begin
                        c1x_q <= C1X;
                        c1y_q <= C1Y;
                        c2x_q <= C2X;
                        c2y_q <= C2Y;
                        idx   <= '0;
                        acc   <= '0;
                    end
                end
                S_EVAL: begin
                    acc <= acc + CW'(covered);
                    idx <= idx + PW'(1);
                    if (idx == LAST) count_q <= acc + CW'(covered);
                end
                S_HOLD: begin
                    if (OUT_READY) wr_ptr <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_laser_cover_eval.sv
// Self-checking bench for laser_cover_eval: directed frame table, corner sequences
// and randomized frames scored by a distance-based reference model.
module tb_laser_cover_eval;
    localparam int NPTS = 40;
    localparam int CW   = 6;

    logic          CLK = 0;
    logic          RST = 1;
    logic          IN_VALID = 0;
    logic [3:0]    X = 0, Y = 0;
    logic          DONE = 0;
    logic [3:0]    C1X = 0, C1Y = 0, C2X = 0, C2Y = 0;
    logic          OUT_READY = 0;
    logic [CW-1:0] COUNT;
    logic          COUNT_VALID;
    logic          BUSY;

    laser_cover_eval #(.NPTS(NPTS), .RADIUS_SQ(16), .CW(CW)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .X(X), .Y(Y), .DONE(DONE),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .OUT_READY(OUT_READY),
        .COUNT(COUNT), .COUNT_VALID(COUNT_VALID), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string name;
        int    kind;
        int    c1x, c1y, c2x, c2y;
        int    exp_count;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int px [48];
    int py [48];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Union-of-discs count using signed integer geometry.
    function automatic int model_count(input int ax, input int ay, input int bx, input int by);
        int n = 0;
        for (int i = 0; i < NPTS; i++) begin
            int d1 = (px[i] - ax) ** 2 + (py[i] - ay) ** 2;
            int d2 = (px[i] - bx) ** 2 + (py[i] - by) ** 2;
            if (d1 <= 16 || d2 <= 16) n++;
        end
        return n;
    endfunction

    task automatic fill_kind(input int kind);
        for (int i = 0; i < 48; i++) begin
            case (kind)
                0: begin px[i] = 8; py[i] = 8; end
                1: begin px[i] = (i < 20) ? 2 : 13; py[i] = px[i]; end
                default: begin px[i] = 15; py[i] = 0; end
            endcase
        end
        if (kind == 2) begin
            px[0] = 4;  py[0] = 0;
            px[1] = 0;  py[1] = 4;
            px[2] = 3;  py[2] = 3;
            px[3] = 15; py[3] = 15;
        end
    endtask

    task automatic fill_random(input int ax, input int ay, input int bx, input int by);
        for (int i = 0; i < 48; i++) begin
            int sel = $urandom_range(0, 9);
            int bxv = (sel < 4) ? ax : bx;
            int byv = (sel < 4) ? ay : by;
            if (sel >= 8) begin
                px[i] = $urandom_range(0, 15);
                py[i] = $urandom_range(0, 15);
            end else begin
                px[i] = bxv + $urandom_range(0, 10) - 5;
                py[i] = byv + $urandom_range(0, 10) - 5;
                if (px[i] < 0) px[i] = 0;
                if (px[i] > 15) px[i] = 15;
                if (py[i] < 0) py[i] = 0;
                if (py[i] > 15) py[i] = 15;
            end
        end
    endtask

    // Called and returns at a negedge.
    task automatic send_frame(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                IN_VALID = 0;
                @(negedge CLK);
            end
            IN_VALID = 1;
            X = 4'(px[i]);
            Y = 4'(py[i]);
            @(negedge CLK);
        end
        IN_VALID = 0;
    endtask

    // Raises DONE, scrambles centres after the sample edge, measures latency and BUSY span.
    task automatic run_eval(input string name, input int ax, input int ay, input int bx,
                            input int by, input int exp);
        int cnt = 0;
        int busy_cnt = 0;
        int overlap = 0;
        DONE = 1;
        C1X = 4'(ax); C1Y = 4'(ay); C2X = 4'(bx); C2Y = 4'(by);
        @(negedge CLK);
        C1X = 4'($urandom); C1Y = 4'($urandom); C2X = 4'($urandom); C2Y = 4'($urandom);
        while (!COUNT_VALID && cnt < 200) begin
            if (BUSY) busy_cnt++;
            @(negedge CLK);
            cnt++;
        end
        if (BUSY && COUNT_VALID) overlap = 1;
        check({name, "_latency"}, cnt, 40);
        check({name, "_busy_cycles"}, busy_cnt, 40);
        check({name, "_busy_valid_overlap"}, overlap, 0);
        check({name, "_count"}, int'(COUNT), exp);
    endtask

    // Ready edge also carries a stray point that must not be stored.
    task automatic accept(input string name, input int exp);
        OUT_READY = 1;
        IN_VALID = 1;
        X = 4'($urandom); Y = 4'($urandom);
        DONE = 0;
        @(negedge CLK);
        OUT_READY = 0;
        IN_VALID = 0;
        check({name, "_valid_cleared"}, int'(COUNT_VALID), 0);
        check({name, "_count_kept"}, int'(COUNT), exp);
    endtask

    vec_t vecs [4];

    initial begin
        int exp;
        int ax, ay, bx, by;
        int cnt, busy_cnt;

        vecs[0] = '{"all_center", 0, 8, 8, 0, 0, 40};
        vecs[1] = '{"two_clusters", 1, 2, 2, 13, 13, 40};
        vecs[2] = '{"no_double", 1, 2, 2, 2, 2, 20};
        vecs[3] = '{"boundary", 2, 0, 0, 0, 0, 2};

        #3;
        check("reset_count", int'(COUNT), 0);
        check("reset_valid", int'(COUNT_VALID), 0);
        check("reset_busy", int'(BUSY), 0);
        @(negedge CLK);
        RST = 0;
        @(negedge CLK);

        foreach (vecs[v]) begin
            fill_kind(vecs[v].kind);
            send_frame(NPTS, 0);
            run_eval(vecs[v].name, vecs[v].c1x, vecs[v].c1y, vecs[v].c2x, vecs[v].c2y,
                     vecs[v].exp_count);
            accept(vecs[v].name, vecs[v].exp_count);
        end

        // DONE raised mid-collect, 45 pulses; extras must be dropped.
        ax = 5; ay = 5; bx = 11; by = 9;
        fill_random(ax, ay, bx, by);
        exp = model_count(ax, ay, bx, by);
        send_frame(20, 0);
        DONE = 1;
        C1X = 4'(ax); C1Y = 4'(ay); C2X = 4'(bx); C2Y = 4'(by);
        for (int i = 20; i < NPTS; i++) begin
            IN_VALID = 1; X = 4'(px[i]); Y = 4'(py[i]);
            @(negedge CLK);
        end
        cnt = 1;
        busy_cnt = 0;
        for (int i = NPTS; i < 45; i++) begin
            IN_VALID = 1; X = 4'(px[i]); Y = 4'(py[i]);
            if (BUSY) busy_cnt++;
            @(negedge CLK);
            cnt++;
        end
        IN_VALID = 0;
        C1X = 4'($urandom); C2Y = 4'($urandom);
        while (!COUNT_VALID && cnt < 200) begin
            if (BUSY) busy_cnt++;
            @(negedge CLK);
            cnt++;
        end
        check("overrun_latency", cnt, 42);
        check("overrun_busy_cycles", busy_cnt, 40);
        check("overrun_count", int'(COUNT), exp);
        accept("overrun", exp);

        // HOLD stays stable while ready is low and other inputs toggle.
        ax = 7; ay = 3; bx = 3; by = 12;
        fill_random(ax, ay, bx, by);
        exp = model_count(ax, ay, bx, by);
        send_frame(NPTS, 1);
        run_eval("hold", ax, ay, bx, by, exp);
        for (int k = 0; k < 10; k++) begin
            IN_VALID = 1'($urandom);
            DONE = 1'($urandom);
            X = 4'($urandom); Y = 4'($urandom);
            @(negedge CLK);
            check("hold_count_stable", int'(COUNT), exp);
            check("hold_valid_stable", int'(COUNT_VALID), 1);
        end
        accept("hold", exp);
        ax = 10; ay = 10; bx = 1; by = 14;
        fill_random(ax, ay, bx, by);
        exp = model_count(ax, ay, bx, by);
        send_frame(NPTS, 0);
        run_eval("after_hold", ax, ay, bx, by, exp);
        accept("after_hold", exp);

        // Asynchronous reset in the middle of evaluation.
        fill_random(4, 4, 12, 12);
        send_frame(NPTS, 0);
        DONE = 1;
        C1X = 4; C1Y = 4; C2X = 12; C2Y = 12;
        @(negedge CLK);
        for (int k = 0; k < 20; k++) @(negedge CLK);
        check("mid_eval_busy", int'(BUSY), 1);
        #2 RST = 1;
        #1;
        check("async_rst_count", int'(COUNT), 0);
        check("async_rst_valid", int'(COUNT_VALID), 0);
        check("async_rst_busy", int'(BUSY), 0);
        #1 RST = 0;
        DONE = 0;
        @(negedge CLK);
        ax = 6; ay = 9; bx = 13; by = 2;
        fill_random(ax, ay, bx, by);
        exp = model_count(ax, ay, bx, by);
        send_frame(NPTS, 1);
        run_eval("post_reset", ax, ay, bx, by, exp);
        accept("post_reset", exp);

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            ax = $urandom_range(0, 15); ay = $urandom_range(0, 15);
            bx = $urandom_range(0, 15); by = $urandom_range(0, 15);
            fill_random(ax, ay, bx, by);
            exp = model_count(ax, ay, bx, by);
            send_frame(NPTS, 1);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            run_eval("random", ax, ay, bx, by, exp);
            accept("random", exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/laser_cover_eval.md
Name: laser_cover_eval

Overview:
- Downstream consumer of the laser-placement stage.
- Snoops the same 40-point X/Y input stream and stores it locally.
- When the placement stage raises DONE, the block latches the two chosen centres (C1X/C1Y, C2X/C2Y). It then recounts, one point per cycle, how many stored points lie within radius 4 of either centre.
- It presents that coverage count through a valid/ready handshake, for scoring and for self-check against the placement result.

Parameters:
- NPTS, 40, number of points per frame; also the evaluation cycle count.
- RADIUS_SQ, 16, inclusive squared-radius threshold.
- CW, 6, width of COUNT; must satisfy 2^CW > NPTS.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- IN_VALID  in  1  X/Y carry a valid point this cycle.
- X  in  4  point x coordinate.
- Y  in  4  point y coordinate.
- DONE  in  1  placement result valid; level signal, held high by upstream.
- C1X  in  4  centre 1 x.
- C1Y  in  4  centre 1 y.
- C2X  in  4  centre 2 x.
- C2Y  in  4  centre 2 y.
- OUT_READY  in  1  consumer accepts COUNT.
- COUNT  out  CW  number of points covered by the union of the two circles.
- COUNT_VALID  out  1  COUNT is final and stable.
- BUSY  out  1  high while in EVAL.

Behaviour:
- Reset (RST=1, asynchronous): state=COLLECT, wr_ptr=0, idx=0, COUNT=0, COUNT_VALID=0, BUSY=0. Point storage is not cleared.
- Reset mid-operation: any state aborts immediately to the reset values above. A partial frame is discarded.

State machine (states COLLECT, WAIT_DONE, EVAL, HOLD):
- COLLECT
  - Each edge with IN_VALID=1 stores (X,Y) at wr_ptr, then wr_ptr+1.
  - The edge that stores point NPTS-1 moves to WAIT_DONE.
  - DONE is ignored in COLLECT.
- WAIT_DONE
  - IN_VALID is ignored; extra points are dropped, not wrapped.
  - The first edge with DONE=1 latches C1X..C2Y into internal registers, clears idx and the internal accumulator, sets BUSY=1, and moves to EVAL.
- EVAL
  - Each edge evaluates point[idx] against the latched centres.
  - dx = |Px - Cx| and dy = |Py - Cy|, computed as 4-bit unsigned absolute differences with no wrap.
  - d² = dx² + dy², 9 bits unsigned.
  - A point is covered if d²(C1) ≤ RADIUS_SQ OR d²(C2) ≤ RADIUS_SQ. A point inside both circles counts once.
  - The accumulator increments by 1 per covered point; it cannot overflow (max NPTS).
  - The edge evaluating idx=NPTS-1 writes the final value to COUNT, sets COUNT_VALID=1, clears BUSY, and moves to HOLD.
- HOLD
  - COUNT and COUNT_VALID are held stable. IN_VALID and DONE are ignored.
  - An edge with OUT_READY=1 clears COUNT_VALID, clears wr_ptr, and returns to COLLECT. COUNT keeps its last value.

Latency and timing:
- Centres are sampled at edge E (DONE sampled high in WAIT_DONE).
- COUNT_VALID is first high after edge E+NPTS (edge E+40).
- A ready-high sample at the HOLD→COLLECT edge does not store a point.
- Changes on C1X..C2Y after edge E have no effect on the result.
- COUNT_VALID and BUSY are never high together.
- COUNT changes only on the EVAL→HOLD edge or at reset.

Test Plan:
- 40 points all at (8,8), C1=(8,8), C2=(0,0), DONE after the frame -> COUNT=40; COUNT_VALID rises exactly 40 edges after the DONE-sample edge; BUSY high for those 40 cycles.
- 20 points at (2,2) and 20 at (13,13). With C1=(2,2), C2=(13,13) -> COUNT=40. Second frame, same points, C1=C2=(2,2) -> COUNT=20 (no double count).
- Boundary frame with centre (0,0) (C1=C2=(0,0)): points (4,0) and (0,4) covered (d²=16); (3,3) not covered (d²=18); (15,15) not covered; 36 filler points at (15,0) not covered -> COUNT=2.
- DONE held high from mid-COLLECT, and 45 IN_VALID pulses sent -> only the first 40 points stored; evaluation starts the edge after point 40 is stored; COUNT matches a model built on the first 40 points.
- OUT_READY held low for 10 cycles in HOLD while IN_VALID and DONE toggle -> COUNT and COUNT_VALID stable; ready high for one edge -> COUNT_VALID=0, state=COLLECT; next frame evaluates correctly.
- RST pulsed asynchronously (between edges) at idx=20 of EVAL -> COUNT=0, COUNT_VALID=0, BUSY=0 immediately; a fresh 40-point frame afterwards gives the correct count.
